control_fsm: RTL and testbench
==============================

# control_fsm

Multi-cycle sequencer for the RV32 core: walks each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK. It drives the datapath muxes, register write enables and the memory request handshake. It also supplies the opcode to the ALU and consumes the ALU's `is_zero`/`is_less` flags to resolve branches. It sits directly upstream of the ALU; the datapath registers (pc, old_pc, ir, a/b, alu_out, mdr) are owned by the datapath and are only enabled from here.

## Interface
- `DATA_WIDTH`, 32, datapath width (used only by the package typedefs)
- `clk_i`  in  1  clock
- `rst_ni`  in  1  reset; synchronous, active-low
- `opcode_i`  in  opcode  decoded from ir
- `funct3_i`  in  3  ir[14:12]
- `mem_ready_i`  in  1  memory completes the current request
- `is_zero_i`, `is_less_i`  in  1 each  ALU flags (signed compare)
- `mem_req_o`, `mem_we_o`  out  1 each  memory request / write
- `addr_sel_o`  out  1  0 = pc, 1 = alu_out
- `ir_we_o`, `pc_we_o`, `alu_out_we_o`, `rf_we_o`  out  1 each  register enables
- `pc_src_o`  out  1  0 = pc+4, 1 = alu_out
- `alu_a_sel_o`  out  2  RS1 = 0, OLD_PC = 1, ZERO = 2
- `alu_b_sel_o`  out  1  0 = rs2, 1 = imm
- `alu_opcode_o`  out  opcode  opcode presented to the ALU
- `wb_sel_o`  out  2  ALU_OUT = 0, MEM = 1, LINK = 2 (old_pc+4)
- `retire_o`  out  1  one-cycle pulse per completed instruction
- `halted_o`, `illegal_o`  out  1 each  sticky status

## Operation
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT, TRAP.
- All outputs are combinational from state and inputs. Unlisted outputs are 0 in every state.
- **FETCH**
  - `mem_req_o`=1, `addr_sel_o`=0.
  - On `mem_ready_i`: `ir_we_o`=1 (datapath also latches old_pc), `pc_we_o`=1 with `pc_src_o`=0, then go to DECODE.
  - Otherwise stay in FETCH.
- **DECODE**
  - Branch/jump target precomputed: `alu_a_sel_o`=OLD_PC, `alu_b_sel_o`=1, `alu_opcode_o`=AUIPC (add), `alu_out_we_o`=1.
  - Next state is EXECUTE, except: SYSTEM goes to HALT; any opcode outside {R, IMMEDIATE, LOAD, STORE, BRANCH, JAL, LUI, AUIPC, SYSTEM} goes to TRAP.
- **EXECUTE** (`alu_opcode_o`=`opcode_i`)
  - R: a = RS1, b = rs2, `alu_out_we_o`=1, then WRITEBACK.
  - IMMEDIATE: a = RS1, b = imm, `alu_out_we_o`=1, then WRITEBACK.
  - LOAD/STORE: a = RS1, b = imm, `alu_out_we_o`=1, then MEM.
  - LUI: a = ZERO, b = imm, `alu_out_we_o`=1, then WRITEBACK.
  - AUIPC: a = OLD_PC, b = imm, `alu_out_we_o`=1, then WRITEBACK.
  - BRANCH: a = RS1, b = rs2, `alu_out_we_o`=0 (target preserved).
    - Taken conditions: funct3 000 `is_zero`, 001 `!is_zero`, 100 `is_less`, 101 `!is_less`.
    - Taken: `pc_we_o`=1, `pc_src_o`=1.
    - `retire_o`=1, then FETCH.
    - Any other funct3 goes to TRAP with no pc write and no retire.
  - JAL: `pc_we_o`=1, `pc_src_o`=1, then WRITEBACK.
- **MEM**
  - `mem_req_o`=1, `addr_sel_o`=1, `mem_we_o` = (opcode == STORE).
  - Wait for `mem_ready_i`. On ready: LOAD goes to WRITEBACK (datapath latches mdr); STORE asserts `retire_o` and goes to FETCH.
- **WRITEBACK**
  - `rf_we_o`=1; `wb_sel_o` = MEM for LOAD, LINK for JAL, otherwise ALU_OUT.
  - `retire_o`=1, then FETCH.
- **HALT**: `halted_o`=1; absorbing until reset.
- **TRAP**: `illegal_o`=1; absorbing until reset.

## Timing
- Memory handshake:
  - Once `mem_req_o` rises, it and `addr_sel_o`/`mem_we_o` stay stable until the cycle `mem_ready_i` is sampled high.
  - Ready in the same cycle as req is legal (zero-wait).
  - `mem_ready_i` is ignored when `mem_req_o`=0.
- Cycles per instruction with zero-wait memory (each memory wait cycle adds 1):
  - R, IMMEDIATE, LUI, AUIPC, JAL: 4.
  - LOAD: 5.
  - STORE: 4.
  - BRANCH: 3.
- Reset:
  - While `rst_ni`=0, all outputs are forced to 0.
  - At any edge with `rst_ni`=0, state becomes FETCH. This applies mid-operation too, including an outstanding memory request: it is dropped without waiting for ready.
  - First cycle after release: FETCH with `mem_req_o`=1.
- `retire_o` is asserted for exactly one cycle per instruction, coincident with the final state's last cycle.

## Structure
- Shared package gets:
  - `ctrl_state_e`;
  - the select enums (`alu_a_sel_e`, `wb_sel_e`);
  - a `BRANCH` entry in `opcode` if it is not already present;
  - the branch funct3 constants.
- One sub-module, `branch_resolve`:
  - combinational;
  - inputs: `funct3_i`, `is_zero_i`, `is_less_i`;
  - outputs: `taken_o`, `illegal_o`.

## Test plan
- R add, ready tied 1: pc 0x00 → 0x04 after FETCH. Observe 4 cycles, `rf_we_o` in cycle 4 with `wb_sel_o`=ALU_OUT, and one `retire_o`.
- LOAD with `mem_ready_i` delayed 3 cycles in both FETCH and MEM:
  - `mem_req_o` held high throughout each wait with `addr_sel_o` stable;
  - total 11 cycles;
  - `wb_sel_o`=MEM.
- BEQ with `is_zero_i`=1 → `pc_we_o`/`pc_src_o`=1 in EXECUTE; with `is_zero_i`=0 → no pc write. Both cases take 3 cycles.
- BLT/BGE with `is_less_i` toggled → taken exactly when {BLT, 1} or {BGE, 0}. funct3=010 → TRAP, `illegal_o`=1, no retire.
- SYSTEM → HALT. `halted_o`=1 and `mem_req_o` stays 0 for 20 cycles. Then `rst_ni`=0 for 1 cycle → FETCH.
- Reset asserted during a MEM wait of a STORE → `mem_req_o` and `mem_we_o` drop at that edge, next state is FETCH, and no retire occurs.

Source files
------------

// File: rtl/control_fsm_pkg.sv
// Shared types for the multi-cycle RV32 control sequencer: opcodes, FSM states,
// datapath select encodings and branch funct3 codes.
package control_fsm_pkg;

    localparam int DATA_WIDTH = 32;

    typedef logic [DATA_WIDTH-1:0] word_t;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_IMM    = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_STORE  = 7'b0100011,
        OPC_R      = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JAL    = 7'b1101111,
        OPC_SYSTEM = 7'b1110011
    } opcode_e;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEM,
        ST_WRITEBACK,
        ST_HALT,
        ST_TRAP
    } ctrl_state_e;

    typedef enum logic [1:0] {
        ALU_A_RS1    = 2'd0,
        ALU_A_OLD_PC = 2'd1,
        ALU_A_ZERO   = 2'd2
    } alu_a_sel_e;

    typedef enum logic [1:0] {
        WB_ALU_OUT = 2'd0,
        WB_MEM     = 2'd1,
        WB_LINK    = 2'd2
    } wb_sel_e;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    function automatic logic is_known_opcode(input opcode_e op);
        case (op)
            OPC_R, OPC_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
            OPC_JAL, OPC_LUI, OPC_AUIPC, OPC_SYSTEM: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/control_fsm_branch_resolve.sv
// Combinational branch condition evaluation from funct3 and the ALU's
// signed-compare flags; unsupported funct3 codes are flagged illegal.
module branch_resolve
    import control_fsm_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       is_zero_i,
    input  logic       is_less_i,
    output logic       taken_o,
    output logic       illegal_o
);

    always_comb begin
        taken_o   = 1'b0;
        illegal_o = 1'b0;
        case (funct3_i)
            F3_BEQ:  taken_o   = is_zero_i;
            F3_BNE:  taken_o   = !is_zero_i;
            F3_BLT:  taken_o   = is_less_i;
            F3_BGE:  taken_o   = !is_less_i;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle RV32 sequencer: walks FETCH/DECODE/EXECUTE/MEM/WRITEBACK and drives
// the datapath enables, mux selects, ALU opcode and memory handshake.
module control_fsm
    import control_fsm_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  opcode_e    opcode_i,
    input  logic [2:0] funct3_i,
    input  logic       mem_ready_i,
    input  logic       is_zero_i,
    input  logic       is_less_i,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       addr_sel_o,
    output logic       ir_we_o,
    output logic       pc_we_o,
    output logic       alu_out_we_o,
    output logic       rf_we_o,
    output logic       pc_src_o,
    output alu_a_sel_e alu_a_sel_o,
    output logic       alu_b_sel_o,
    output opcode_e    alu_opcode_o,
    output wb_sel_e    wb_sel_o,
    output logic       retire_o,
    output logic       halted_o,
    output logic       illegal_o
);

    ctrl_state_e state;
    ctrl_state_e state_next;
    logic        br_taken;
    logic        br_illegal;

    branch_resolve u_branch_resolve (
        .funct3_i  (funct3_i),
        .is_zero_i (is_zero_i),
        .is_less_i (is_less_i),
        .taken_o   (br_taken),
        .illegal_o (br_illegal)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= ST_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Outputs are decoded straight from state and inputs; everything is held at 0 while in reset.
    always_comb begin
        state_next   = state;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        addr_sel_o   = 1'b0;
        ir_we_o      = 1'b0;
        pc_we_o      = 1'b0;
        alu_out_we_o = 1'b0;
        rf_we_o      = 1'b0;
        pc_src_o     = 1'b0;
        alu_a_sel_o  = ALU_A_RS1;
        alu_b_sel_o  = 1'b0;
        alu_opcode_o = opcode_e'(7'd0);
        wb_sel_o     = WB_ALU_OUT;
        retire_o     = 1'b0;
        halted_o     = 1'b0;
        illegal_o    = 1'b0;

        if (rst_ni) begin
            case (state)
                ST_FETCH: begin
                    mem_req_o = 1'b1;
                    if (mem_ready_i) begin
                        ir_we_o    = 1'b1;
                        pc_we_o    = 1'b1;
                        state_next = ST_DECODE;
                    end
                end

                ST_DECODE: begin
                    alu_a_sel_o  = ALU_A_OLD_PC;
                    alu_b_sel_o  = 1'b1;
                    alu_opcode_o = OPC_AUIPC;
                    alu_out_we_o = 1'b1;
                    if (opcode_i == OPC_SYSTEM) begin
                        state_next = ST_HALT;
                    end else if (!is_known_opcode(opcode_i)) begin
                        state_next = ST_TRAP;
                    end else begin
                        state_next = ST_EXECUTE;
                    end
                end

                ST_EXECUTE: begin
                    alu_opcode_o = opcode_i;
                    case (opcode_i)
                        OPC_R: begin
                            alu_out_we_o = 1'b1;
                            state_next   = ST_WRITEBACK;
                        end
                        OPC_IMM: begin
                            alu_b_sel_o  = 1'b1;
                            alu_out_we_o = 1'b1;
                            state_next   = ST_WRITEBACK;
                        end
                        OPC_LOAD, OPC_STORE: begin
                            alu_b_sel_o  = 1'b1;
                            alu_out_we_o = 1'b1;
                            state_next   = ST_MEM;
                        end
                        OPC_LUI: begin
                            alu_a_sel_o  = ALU_A_ZERO;
                            alu_b_sel_o  = 1'b1;
                            alu_out_we_o = 1'b1;
                            state_next   = ST_WRITEBACK;
                        end
                        OPC_AUIPC: begin
                            alu_a_sel_o  = ALU_A_OLD_PC;
                            alu_b_sel_o  = 1'b1;
                            alu_out_we_o = 1'b1;
                            state_next   = ST_WRITEBACK;
                        end
                        // alu_out keeps the target computed in DECODE, so it is not rewritten here.
                        OPC_BRANCH: begin
                            if (br_illegal) begin
                                state_next = ST_TRAP;
                            end else begin
                                pc_we_o    = br_taken;
                                pc_src_o   = br_taken;
                                retire_o   = 1'b1;
                                state_next = ST_FETCH;
                            end
                        end
                        OPC_JAL: begin
                            pc_we_o    = 1'b1;
                            pc_src_o   = 1'b1;
                            state_next = ST_WRITEBACK;
                        end
                        default: state_next = ST_TRAP;
                    endcase
                end

                ST_MEM: begin
                    mem_req_o  = 1'b1;
                    addr_sel_o = 1'b1;
                    mem_we_o   = (opcode_i == OPC_STORE);
                    if (mem_ready_i) begin
                        if (opcode_i == OPC_STORE) begin
                            retire_o   = 1'b1;
                            state_next = ST_FETCH;
                        end else begin
                            state_next = ST_WRITEBACK;
                        end
                    end
                end

                ST_WRITEBACK: begin
                    rf_we_o = 1'b1;
                    if (opcode_i == OPC_LOAD) begin
                        wb_sel_o = WB_MEM;
                    end else if (opcode_i == OPC_JAL) begin
                        wb_sel_o = WB_LINK;
                    end
                    retire_o   = 1'b1;
                    state_next = ST_FETCH;
                end

                ST_HALT: halted_o = 1'b1;

                ST_TRAP: illegal_o = 1'b1;

                default: state_next = ST_TRAP;
            endcase
        end
    end

endmodule

// File: tb/tb_control_fsm.sv
// Directed, table-driven bench for control_fsm: one vector per clock cycle with
// hand-computed expected outputs, plus hand-written halt and reset-abort sequences.
module tb_control_fsm;
    import control_fsm_pkg::*;

    logic       clk;
    logic       rst_n;
    opcode_e    opcode;
    logic [2:0] funct3;
    logic       mem_ready;
    logic       is_zero;
    logic       is_less;
    logic       mem_req, mem_we, addr_sel, ir_we, pc_we, alu_out_we, rf_we, pc_src;
    alu_a_sel_e alu_a_sel;
    logic       alu_b_sel;
    opcode_e    alu_opcode;
    wb_sel_e    wb_sel;
    logic       retire, halted, illegal;

    int checks = 0;
    int errors = 0;

    control_fsm dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .opcode_i     (opcode),
        .funct3_i     (funct3),
        .mem_ready_i  (mem_ready),
        .is_zero_i    (is_zero),
        .is_less_i    (is_less),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .addr_sel_o   (addr_sel),
        .ir_we_o      (ir_we),
        .pc_we_o      (pc_we),
        .alu_out_we_o (alu_out_we),
        .rf_we_o      (rf_we),
        .pc_src_o     (pc_src),
        .alu_a_sel_o  (alu_a_sel),
        .alu_b_sel_o  (alu_b_sel),
        .alu_opcode_o (alu_opcode),
        .wb_sel_o     (wb_sel),
        .retire_o     (retire),
        .halted_o     (halted),
        .illegal_o    (illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected output bundle, fields left to right:
    // {mem_req,mem_we,addr_sel}_{ir_we,pc_we,pc_src,alu_out_we,rf_we}_{alu_a_sel}_{alu_b_sel}_{wb_sel}_{retire,halted,illegal}
    localparam logic [15:0] P_ZERO        = 16'b000_00000_00_0_00_000;
    localparam logic [15:0] P_FETCH_WAIT  = 16'b100_00000_00_0_00_000;
    localparam logic [15:0] P_FETCH_RDY   = 16'b100_11000_00_0_00_000;
    localparam logic [15:0] P_DECODE      = 16'b000_00010_01_1_00_000;
    localparam logic [15:0] P_EX_RR       = 16'b000_00010_00_0_00_000;
    localparam logic [15:0] P_EX_RI       = 16'b000_00010_00_1_00_000;
    localparam logic [15:0] P_EX_LUI      = 16'b000_00010_10_1_00_000;
    localparam logic [15:0] P_EX_AUIPC    = 16'b000_00010_01_1_00_000;
    localparam logic [15:0] P_EX_JAL      = 16'b000_01100_00_0_00_000;
    localparam logic [15:0] P_BR_TAKEN    = 16'b000_01100_00_0_00_100;
    localparam logic [15:0] P_BR_NOT      = 16'b000_00000_00_0_00_100;
    localparam logic [15:0] P_MEM_LD      = 16'b101_00000_00_0_00_000;
    localparam logic [15:0] P_MEM_ST      = 16'b111_00000_00_0_00_000;
    localparam logic [15:0] P_MEM_ST_DONE = 16'b111_00000_00_0_00_100;
    localparam logic [15:0] P_WB_ALU      = 16'b000_00001_00_0_00_100;
    localparam logic [15:0] P_WB_MEM      = 16'b000_00001_00_0_01_100;
    localparam logic [15:0] P_WB_LINK     = 16'b000_00001_00_0_10_100;
    localparam logic [15:0] P_HALT        = 16'b000_00000_00_0_00_010;
    localparam logic [15:0] P_TRAP        = 16'b000_00000_00_0_00_001;
    localparam opcode_e     NONE          = opcode_e'(7'd0);

    typedef struct {
        logic       rst_n;
        opcode_e    op;
        logic [2:0] f3;
        logic       rdy;
        logic       z;
        logic       lt;
        logic [15:0] exp;
        opcode_e    aop;
    } vec_t;

    vec_t vecs[$];
    int   vecIdx = 0;

    function automatic void add(input logic r, input opcode_e op, input logic [2:0] f3,
                                input logic rdy, input logic z, input logic lt,
                                input logic [15:0] e, input opcode_e aop);
        vec_t v;
        v.rst_n = r; v.op = op; v.f3 = f3; v.rdy = rdy; v.z = z; v.lt = lt;
        v.exp = e; v.aop = aop;
        vecs.push_back(v);
    endfunction

    // Four-cycle ALU-type instruction with ready tied high, including an ignored ready in DECODE.
    function automatic void addAluInstr(input opcode_e op, input logic [15:0] exEx,
                                        input logic [15:0] wbEx);
        add(1, op, 3'b000, 1, 0, 0, P_FETCH_RDY, NONE);
        add(1, op, 3'b000, 1, 0, 0, P_DECODE,    OPC_AUIPC);
        add(1, op, 3'b000, 1, 0, 0, exEx,        op);
        add(1, op, 3'b000, 1, 0, 0, wbEx,        NONE);
    endfunction

    function automatic void addBranch(input logic [2:0] f3, input logic z, input logic lt,
                                      input logic [15:0] exEx);
        add(1, OPC_BRANCH, f3, 1, z, lt, P_FETCH_RDY, NONE);
        add(1, OPC_BRANCH, f3, 1, z, lt, P_DECODE,    OPC_AUIPC);
        add(1, OPC_BRANCH, f3, 1, z, lt, exEx,        OPC_BRANCH);
    endfunction

    task automatic applyStimulus(input vec_t v);
        rst_n     = v.rst_n;
        opcode    = v.op;
        funct3    = v.f3;
        mem_ready = v.rdy;
        is_zero   = v.z;
        is_less   = v.lt;
    endtask

    task automatic checkOutput(input vec_t v);
        logic [15:0] obs;
        obs = {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, alu_out_we, rf_we,
               alu_a_sel, alu_b_sel, wb_sel, retire, halted, illegal};
        checks++;
        if ({obs, alu_opcode} !== {v.exp, v.aop}) begin
            errors++;
            $display("[TB] FAIL step%0d op=%s: outputs got %b want %b, alu_opcode got %h want %h",
                     vecIdx, v.op.name(), obs, v.exp, alu_opcode, v.aop);
        end
    endtask

    task automatic runVec(input vec_t v);
        applyStimulus(v);
        @(negedge clk);
        checkOutput(v);
        @(posedge clk);
        #1;
        vecIdx++;
    endtask

    initial begin
        rst_n = 1'b0; opcode = OPC_R; funct3 = 3'b000;
        mem_ready = 1'b0; is_zero = 1'b0; is_less = 1'b0;

        // Reset, then the ALU-type instruction classes.
        add(0, OPC_R, 3'b000, 1, 0, 0, P_ZERO, NONE);
        addAluInstr(OPC_R,     P_EX_RR,    P_WB_ALU);
        addAluInstr(OPC_IMM,   P_EX_RI,    P_WB_ALU);
        addAluInstr(OPC_LUI,   P_EX_LUI,   P_WB_ALU);
        addAluInstr(OPC_AUIPC, P_EX_AUIPC, P_WB_ALU);
        addAluInstr(OPC_JAL,   P_EX_JAL,   P_WB_LINK);

        // LOAD with three wait cycles in both FETCH and MEM: 11 cycles total.
        for (int i = 0; i < 3; i++) add(1, OPC_LOAD, 3'b010, 0, 0, 0, P_FETCH_WAIT, NONE);
        add(1, OPC_LOAD, 3'b010, 1, 0, 0, P_FETCH_RDY, NONE);
        add(1, OPC_LOAD, 3'b010, 0, 0, 0, P_DECODE,    OPC_AUIPC);
        add(1, OPC_LOAD, 3'b010, 0, 0, 0, P_EX_RI,     OPC_LOAD);
        for (int i = 0; i < 3; i++) add(1, OPC_LOAD, 3'b010, 0, 0, 0, P_MEM_LD, NONE);
        add(1, OPC_LOAD, 3'b010, 1, 0, 0, P_MEM_LD,    NONE);
        add(1, OPC_LOAD, 3'b010, 0, 0, 0, P_WB_MEM,    NONE);

        // Zero-wait STORE retires in MEM.
        add(1, OPC_STORE, 3'b010, 1, 0, 0, P_FETCH_RDY,   NONE);
        add(1, OPC_STORE, 3'b010, 1, 0, 0, P_DECODE,      OPC_AUIPC);
        add(1, OPC_STORE, 3'b010, 1, 0, 0, P_EX_RI,       OPC_STORE);
        add(1, OPC_STORE, 3'b010, 1, 0, 0, P_MEM_ST_DONE, NONE);

        // Branch conditions, each retiring in three cycles.
        addBranch(F3_BEQ, 1, 0, P_BR_TAKEN);
        addBranch(F3_BEQ, 0, 1, P_BR_NOT);
        addBranch(F3_BNE, 0, 0, P_BR_TAKEN);
        addBranch(F3_BNE, 1, 0, P_BR_NOT);
        addBranch(F3_BLT, 0, 1, P_BR_TAKEN);
        addBranch(F3_BLT, 1, 0, P_BR_NOT);
        addBranch(F3_BGE, 0, 0, P_BR_TAKEN);
        addBranch(F3_BGE, 0, 1, P_BR_NOT);

        // Unsupported branch funct3 traps without pc write or retire; TRAP is sticky until reset.
        addBranch(3'b010, 1, 1, P_ZERO);
        add(1, OPC_BRANCH, 3'b010, 1, 0, 0, P_TRAP, NONE);
        add(1, OPC_BRANCH, 3'b010, 1, 0, 0, P_TRAP, NONE);
        add(0, OPC_BRANCH, 3'b010, 1, 0, 0, P_ZERO, NONE);

        // Unknown opcode traps out of DECODE.
        add(1, opcode_e'(7'h7f), 3'b000, 1, 0, 0, P_FETCH_RDY, NONE);
        add(1, opcode_e'(7'h7f), 3'b000, 1, 0, 0, P_DECODE,    OPC_AUIPC);
        add(1, opcode_e'(7'h7f), 3'b000, 1, 0, 0, P_TRAP,      NONE);
        add(0, opcode_e'(7'h7f), 3'b000, 1, 0, 0, P_ZERO,      NONE);

        foreach (vecs[i]) runVec(vecs[i]);

        // SYSTEM halts; mem_req stays low for 20 cycles even with ready high, then reset recovers.
        begin
            vec_t v;
            v.rst_n = 1; v.op = OPC_SYSTEM; v.f3 = 3'b000; v.rdy = 1; v.z = 0; v.lt = 0;
            v.exp = P_FETCH_RDY; v.aop = NONE;      runVec(v);
            v.exp = P_DECODE;    v.aop = OPC_AUIPC; runVec(v);
            v.exp = P_HALT;      v.aop = NONE;
            for (int i = 0; i < 20; i++) runVec(v);
            v.rst_n = 0; v.exp = P_ZERO;            runVec(v);
            v.rst_n = 1; v.rdy = 0; v.exp = P_FETCH_WAIT; runVec(v);
            v.rdy = 1;   v.exp = P_FETCH_RDY;       runVec(v);
            v.op = OPC_R; v.rdy = 0; v.exp = P_DECODE; v.aop = OPC_AUIPC; runVec(v);
            v.exp = P_EX_RR; v.aop = OPC_R;         runVec(v);
            v.exp = P_WB_ALU; v.aop = NONE;         runVec(v);
        end

        // Reset during a STORE's MEM wait drops the request without a retire.
        begin
            vec_t v;
            v.rst_n = 1; v.op = OPC_STORE; v.f3 = 3'b010; v.rdy = 1; v.z = 0; v.lt = 0;
            v.exp = P_FETCH_RDY; v.aop = NONE;      runVec(v);
            v.rdy = 0; v.exp = P_DECODE; v.aop = OPC_AUIPC; runVec(v);
            v.exp = P_EX_RI;  v.aop = OPC_STORE;    runVec(v);
            v.exp = P_MEM_ST; v.aop = NONE;         runVec(v);
            runVec(v);
            v.rst_n = 0; v.rdy = 1; v.exp = P_ZERO; runVec(v);
            v.rst_n = 1; v.rdy = 0; v.exp = P_FETCH_WAIT; runVec(v);
            v.rdy = 1;   v.exp = P_FETCH_RDY;       runVec(v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
